// File: rtl/cycle_pkg.sv
// Shared definitions for the bus machine-cycle sequencer: T-state codes,
// cycle-type/status encodings and small decode helpers.
package cycle_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_TR = 4'd0,
        ST_TI = 4'd1,
        ST_T1 = 4'd2,
        ST_T2 = 4'd3,
        ST_TW = 4'd4,
        ST_T3 = 4'd5,
        ST_T4 = 4'd6,
        ST_T5 = 4'd7,
        ST_T6 = 4'd8,
        ST_TH = 4'd9,
        ST_TT = 4'd10
    } tstate_e;

    // Cycle types are encoded as {iom_, s1, s0}
    localparam logic [2:0] CYC_OF   = 3'b011;
    localparam logic [2:0] CYC_MR   = 3'b010;
    localparam logic [2:0] CYC_MW   = 3'b001;
    localparam logic [2:0] CYC_DR   = 3'b110;
    localparam logic [2:0] CYC_DW   = 3'b101;
    localparam logic [2:0] CYC_INTA = 3'b111;

    // Reset status: s1=0, s0=1, iom_=1, held as {iom_, s1, s0}
    localparam logic [2:0] STATUS_RESET = 3'b101;

    function automatic logic isBusIdle(input logic [2:0] t);
        return (t == 3'b000) || (t == 3'b100);
    endfunction

    function automatic logic isReadType(input logic [2:0] t);
        return (t == CYC_OF) || (t == CYC_MR) || (t == CYC_DR);
    endfunction

    function automatic logic isWriteType(input logic [2:0] t);
        return (t == CYC_MW) || (t == CYC_DW);
    endfunction

endpackage

// File: rtl/wait_count.sv
// Loadable down-counter for wait states; saturates at zero and flags it.
module wait_count #(
    parameter int WAITBITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                dec_i,
    input  logic [WAITBITS-1:0] value_i,
    output logic                zero_o
);

    logic [WAITBITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WAITBITS'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cycle_seq.sv
// Machine-cycle T-state sequencer: walks T1..T6 with wait states, and handles
// hold/halt; every output is decoded from registered state only.
module cycle_seq
    import cycle_pkg::*;
#(
    parameter int WAITBITS = 2,
    parameter int TSTSIZE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [2:0]          cyc_type,
    input  logic                six,
    input  logic [WAITBITS-1:0] nwait,
    input  logic                ready,
    input  logic                hold,
    input  logic                halt_req,
    input  logic                intr,
    output logic                s0,
    output logic                s1,
    output logic                iom_,
    output logic                ale,
    output logic                rd_,
    output logic                wr_,
    output logic                inta_,
    output logic                hlda,
    output logic                bus_en,
    output logic                done,
    output logic                halted,
    output logic [TSTSIZE-1:0]  tstate
);

    tstate_e             state_q, state_d;
    logic [2:0]          type_q, type_d;
    logic                six_q, six_d;
    logic [WAITBITS-1:0] nwait_q, nwait_d;
    logic                fromTT_q, fromTT_d;
    logic                cntLoad, cntDec, cntZero;
    logic                finalState, startCycle, strobeWin;

    wait_count #(.WAITBITS(WAITBITS)) u_wait_count (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (cntLoad),
        .dec_i  (cntDec),
        .value_i(nwait_q),
        .zero_o (cntZero)
    );

    assign finalState = ((state_q == ST_T3) && (type_q != CYC_OF)) ||
                        ((state_q == ST_T4) && !six_q) ||
                        (state_q == ST_T6);

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        six_d      = six_q;
        nwait_d    = nwait_q;
        fromTT_d   = fromTT_q;
        cntLoad    = 1'b0;
        cntDec     = 1'b0;
        startCycle = 1'b0;

        case (state_q)
            ST_TR: state_d = ST_TI;
            ST_TI: begin
                if (hold) begin
                    state_d  = ST_TH;
                    fromTT_d = 1'b0;
                end else if (halt_req) begin
                    state_d = ST_TT;
                end else if (req) begin
                    startCycle = 1'b1;
                end
            end
            ST_T1: begin
                state_d = ST_T2;
                cntLoad = 1'b1;
            end
            ST_T2, ST_TW: begin
                if (isBusIdle(type_q) || (cntZero && ready)) begin
                    state_d = ST_T3;
                end else begin
                    state_d = ST_TW;
                    cntDec  = 1'b1;
                end
            end
            ST_T3: if (type_q == CYC_OF) state_d = ST_T4;
            ST_T4: if (six_q) state_d = ST_T5;
            ST_T5: state_d = ST_T6;
            ST_TH: if (!hold) state_d = fromTT_q ? ST_TT : ST_TI;
            ST_TT: begin
                if (hold) begin
                    state_d  = ST_TH;
                    fromTT_d = 1'b1;
                end else if (intr) begin
                    state_d = ST_TI;
                end
            end
            default: state_d = ST_TR;
        endcase

        // Hold raised mid-cycle is only acted on here, once the cycle completes
        if (finalState) begin
            if (hold) begin
                state_d  = ST_TH;
                fromTT_d = 1'b0;
            end else if (halt_req) begin
                state_d = ST_TT;
            end else if (req) begin
                startCycle = 1'b1;
            end else begin
                state_d = ST_TI;
            end
        end

        if (startCycle) begin
            state_d = ST_T1;
            type_d  = cyc_type;
            six_d   = six && (cyc_type == CYC_OF);
            nwait_d = nwait;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_TR;
            type_q   <= STATUS_RESET;
            six_q    <= 1'b0;
            nwait_q  <= '0;
            fromTT_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            six_q    <= six_d;
            nwait_q  <= nwait_d;
            fromTT_q <= fromTT_d;
        end
    end

    assign strobeWin = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);

    assign ale    = (state_q == ST_T1);
    assign rd_    = !(strobeWin && isReadType(type_q));
    assign wr_    = !(strobeWin && isWriteType(type_q));
    assign inta_  = !(strobeWin && (type_q == CYC_INTA));
    assign hlda   = (state_q == ST_TH);
    assign halted = (state_q == ST_TT);
    assign done   = finalState;
    assign bus_en = (state_q == ST_T1) || strobeWin || (state_q == ST_T4) ||
                    (state_q == ST_T5) || (state_q == ST_T6);
    assign iom_   = type_q[2];
    assign s1     = halted ? 1'b0 : type_q[1];
    assign s0     = halted ? 1'b0 : type_q[0];
    assign tstate = TSTSIZE'(state_q);

endmodule

// File: tb/tb_cycle_seq.sv
// Bench for cycle_seq: directed vector table, hand-built wait/six sequences,
// then random transactions checked against a per-transaction state-list model.
module tb_cycle_seq;
    import cycle_pkg::*;

    localparam int WAITBITS = 2;
    localparam int TSTSIZE  = 4;

    localparam logic [6:0] IDLE_CTL = 7'b0111000;
    localparam logic [6:0] T1_CTL   = 7'b1111010;
    localparam logic [6:0] RD_CTL   = 7'b0011010;
    localparam logic [6:0] RD_DONE  = 7'b0011011;
    localparam logic [6:0] HOLD_CTL = 7'b0111100;
    localparam logic [6:0] INTA_CTL = 7'b0110010;

    logic clk = 1'b0;
    logic rst, req, six, ready, hold, halt_req, intr;
    logic [2:0] cyc_type;
    logic [WAITBITS-1:0] nwait;
    logic s0, s1, iom_, ale, rd_, wr_, inta_, hlda, bus_en, done, halted;
    logic [TSTSIZE-1:0] tstate;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cycle_seq #(.WAITBITS(WAITBITS), .TSTSIZE(TSTSIZE)) dut (
        .clk(clk), .rst(rst), .req(req), .cyc_type(cyc_type), .six(six),
        .nwait(nwait), .ready(ready), .hold(hold), .halt_req(halt_req), .intr(intr),
        .s0(s0), .s1(s1), .iom_(iom_), .ale(ale), .rd_(rd_), .wr_(wr_),
        .inta_(inta_), .hlda(hlda), .bus_en(bus_en), .done(done),
        .halted(halted), .tstate(tstate)
    );

    typedef struct {
        logic       rst, req;
        logic [2:0] ctype;
        logic       six;
        logic [1:0] nwait;
        logic       ready, hold, haltReq, intr;
        logic [3:0] st;
        logic [2:0] status;
        logic [6:0] ctl;
    } vec_t;

    vec_t vecs[$];

    logic [3:0] seq34 [8] = '{ST_T1, ST_T2, ST_TW, ST_TW, ST_T3, ST_T4, ST_T5, ST_T6};
    logic [3:0] seq35 [6] = '{ST_T1, ST_T2, ST_TW, ST_TW, ST_TW, ST_T3};
    logic       rdy35 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] typePool [8] = '{CYC_OF, CYC_MR, CYC_MW, CYC_DR, CYC_DW, CYC_INTA, 3'b000, 3'b100};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] actCtl();
        return {ale, rd_, wr_, inta_, hlda, bus_en, done};
    endfunction

    function automatic void addVec(input logic r, q, input logic [2:0] ct, input logic sx,
                                   input logic [1:0] nw, input logic rdy, hd, hr, it,
                                   input logic [3:0] st, input logic [2:0] status,
                                   input logic [6:0] ctl);
        vec_t v;
        v.rst = r; v.req = q; v.ctype = ct; v.six = sx; v.nwait = nw;
        v.ready = rdy; v.hold = hd; v.haltReq = hr; v.intr = it;
        v.st = st; v.status = status; v.ctl = ctl;
        vecs.push_back(v);
    endfunction

    // Drive one cycle's inputs and step past the next rising edge
    task automatic applyStimulus(input logic r, q, input logic [2:0] ct, input logic sx,
                                 input logic [1:0] nw, input logic rdy, hd, hr, it);
        rst = r; req = q; cyc_type = ct; six = sx; nwait = nw;
        ready = rdy; hold = hd; halt_req = hr; intr = it;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs of an in-progress cycle (or TI) derived from the bus rules
    task automatic expectState(input string name, input logic [3:0] st,
                               input logic [2:0] t, input logic sx);
        logic win, rdE, wrE, intaE, benE, doneE;
        win   = (st == ST_T2) || (st == ST_TW) || (st == ST_T3);
        rdE   = !(win && (t == CYC_OF || t == CYC_MR || t == CYC_DR));
        wrE   = !(win && (t == CYC_MW || t == CYC_DW));
        intaE = !(win && (t == CYC_INTA));
        benE  = (st != ST_TI);
        doneE = (st == ST_T3 && t != CYC_OF) || (st == ST_T4 && !sx) || (st == ST_T6);
        checkOutput({name, " state"}, 16'(tstate), 16'(st));
        checkOutput({name, " ctl"}, 16'(actCtl()),
                    16'({(st == ST_T1), rdE, wrE, intaE, 1'b0, benE, doneE}));
        checkOutput({name, " status"}, 16'({iom_, s1, s0}), 16'(t));
    endtask

    // One random transaction requested from TI or a final state; ends in its final state
    task automatic runModelTxn(input logic [2:0] t, input logic sx, input logic [1:0] nw);
        logic effSix, bi, rdy;
        logic [3:0] nxt;
        int waitIdx;
        effSix  = sx && (t == CYC_OF);
        bi      = (t == 3'b000) || (t == 3'b100);
        waitIdx = 0;
        applyStimulus(1'b0, 1'b1, t, sx, nw, rb(), 1'b0, 1'b0, rb());
        expectState("rnd T1", ST_T1, t, effSix);
        applyStimulus(1'b0, rb(), 3'($urandom), rb(), 2'($urandom), rb(), 1'b0, 1'b0, rb());
        expectState("rnd T2", ST_T2, t, effSix);
        nxt = ST_T2;
        while (nxt != ST_T3) begin
            rdy = ($urandom_range(99) < 65) || (waitIdx > 20);
            nxt = (bi || (waitIdx >= int'(nw) && rdy)) ? ST_T3 : ST_TW;
            waitIdx++;
            applyStimulus(1'b0, rb(), 3'($urandom), rb(), 2'($urandom), rdy, 1'b0, 1'b0, rb());
            expectState("rnd wait", nxt, t, effSix);
        end
        if (t == CYC_OF) begin
            applyStimulus(1'b0, rb(), 3'($urandom), rb(), 2'($urandom), rb(), 1'b0, 1'b0, rb());
            expectState("rnd T4", ST_T4, t, effSix);
            if (effSix) begin
                applyStimulus(1'b0, rb(), 3'($urandom), rb(), 2'($urandom), rb(), 1'b0, 1'b0, rb());
                expectState("rnd T5", ST_T5, t, effSix);
                applyStimulus(1'b0, rb(), 3'($urandom), rb(), 2'($urandom), rb(), 1'b0, 1'b0, rb());
                expectState("rnd T6", ST_T6, t, effSix);
            end
        end
    endtask

    initial begin
        int rdLow, wrLow;
        logic [2:0] t;

        // Reset, MR, DR with hold in T2, halt then hold/intr, reset during INTA wait
        addVec(1, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TR, STATUS_RESET, IDLE_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TI, STATUS_RESET, IDLE_CTL);
        addVec(0, 1, CYC_MR, 0, 0, 1, 0, 0, 0, ST_T1, CYC_MR, T1_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_T2, CYC_MR, RD_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_T3, CYC_MR, RD_DONE);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TI, CYC_MR, IDLE_CTL);
        addVec(0, 1, CYC_DR, 0, 1, 1, 0, 0, 0, ST_T1, CYC_DR, T1_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 1, 0, 0, ST_T2, CYC_DR, RD_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 1, 0, 0, ST_TW, CYC_DR, RD_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 1, 0, 0, ST_T3, CYC_DR, RD_DONE);
        addVec(0, 0, 3'b000, 0, 0, 1, 1, 0, 0, ST_TH, CYC_DR, HOLD_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 1, 0, 0, ST_TH, CYC_DR, HOLD_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TI, CYC_DR, IDLE_CTL);
        addVec(0, 1, CYC_MR, 0, 0, 1, 0, 0, 0, ST_T1, CYC_MR, T1_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_T2, CYC_MR, RD_CTL);
        addVec(0, 1, 3'b000, 0, 0, 1, 0, 1, 0, ST_T3, CYC_MR, RD_DONE);
        addVec(0, 1, CYC_MW, 0, 0, 1, 0, 1, 0, ST_TT, 3'b000, IDLE_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TT, 3'b000, IDLE_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 1, 0, 0, ST_TH, CYC_MR, HOLD_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TT, 3'b000, IDLE_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 1, ST_TI, CYC_MR, IDLE_CTL);
        addVec(0, 1, CYC_INTA, 0, 3, 1, 0, 0, 0, ST_T1, CYC_INTA, T1_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_T2, CYC_INTA, INTA_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TW, CYC_INTA, INTA_CTL);
        addVec(1, 1, CYC_MR, 0, 0, 1, 1, 1, 1, ST_TR, STATUS_RESET, IDLE_CTL);
        addVec(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, ST_TI, STATUS_RESET, IDLE_CTL);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].ctype, vecs[i].six, vecs[i].nwait,
                          vecs[i].ready, vecs[i].hold, vecs[i].haltReq, vecs[i].intr);
            checkOutput($sformatf("vec%0d state", i), 16'(tstate), 16'(vecs[i].st));
            checkOutput($sformatf("vec%0d status", i), 16'({iom_, s1, s0}), 16'(vecs[i].status));
            checkOutput($sformatf("vec%0d ctl", i), 16'(actCtl()), 16'(vecs[i].ctl));
            checkOutput($sformatf("vec%0d halted", i), 16'(halted), 16'(vecs[i].st == ST_TT));
        end

        // Six-T opcode fetch with two wait states
        rdLow = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i == 0), CYC_OF, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("of6 step%0d state", i), 16'(tstate), 16'(seq34[i]));
            if (!rd_) rdLow++;
        end
        checkOutput("of6 done in T6", 16'(done), 16'd1);
        checkOutput("of6 rd_ low clocks", 16'(rdLow), 16'd4);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("of6 back to TI", 16'(tstate), 16'(ST_TI));

        // Memory write held off by ready for three clocks
        wrLow = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, (i == 0), CYC_MW, 1'b0, 2'd0, rdy35[i], 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("mw step%0d state", i), 16'(tstate), 16'(seq35[i]));
            if (!wr_) wrLow++;
        end
        checkOutput("mw wr_ low clocks", 16'(wrLow), 16'd5);
        checkOutput("mw done in T3", 16'(done), 16'd1);

        // Random transactions, mixing back-to-back requests and idle gaps
        for (int n = 0; n < 150; n++) begin
            t = typePool[$urandom_range(7)];
            runModelTxn(t, rb(), 2'($urandom));
            if ($urandom_range(1) == 0) begin
                applyStimulus(1'b0, 1'b0, 3'($urandom), rb(), 2'($urandom), rb(), 1'b0, 1'b0, rb());
                expectState("rnd gap TI", ST_TI, t, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cycle_seq.md
CYCLE_SEQ -- requirements
Module: cycle_seq

Interface
REQ-001 Parameter WAITBITS, default 2: width of the programmed wait-state count.
REQ-002 Parameter TSTSIZE, default 4: width of the tstate output.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req  in  1  machine-cycle request, sampled only in TI or the final T-state.
REQ-007 cyc_type  in  3  {iom_,s1,s0}: OF=011, MR=010, MW=001, DR=110, DW=101, INTA=111; 000/100 = bus idle (BI).
REQ-008 six  in  1  six-T opcode fetch; honoured only for OF.
REQ-009 nwait  in  WAITBITS  minimum wait states to insert.
REQ-010 ready, hold, halt_req, intr  in  1 each  bus ready, hold request, enter halt, wake from halt.
REQ-011 s0, s1, iom_, ale, rd_, wr_, inta_, hlda, bus_en  out  1 each  bus status, strobes, hold acknowledge, drive enable.
REQ-012 done  out  1  high during the final T-state of a machine cycle.
REQ-013 halted  out  1  high in TT; tstate  out  TSTSIZE  current state code.

Function
REQ-014 States TR, TI, T1, T2, TW, T3, T4, T5, T6, TH, TT; every output is decoded from registered state and latched cycle registers only, with no input-to-output combinational path.
REQ-015 TR -> TI unconditionally; TI: hold -> TH, else halt_req -> TT, else req -> T1, else stay in TI.
REQ-016 Entering T1 latches cyc_type, six and nwait; req and cyc_type are ignored at all other times.
REQ-017 T1 -> T2; ale=1 only in T1.
REQ-018 T2/TW: wait counter loaded with nwait on entry to T2 and decremented each TW; exit to T3 when count=0 and ready=1, else go to or stay in TW.
REQ-019 BI cycles ignore ready and nwait: T2 -> T3 directly.
REQ-020 T3 is final unless type=OF; OF: T3 -> T4; T4 is final unless six=1; six: T4 -> T5 -> T6 (final).
REQ-021 Final state: done=1; next state is TH if hold, else TT if halt_req, else T1 if req (back-to-back, no TI gap), else TI.
REQ-022 hold mid-cycle is deferred to the final state; hold has priority over halt_req, and halt_req over req.
REQ-023 s1, s0, iom_ equal the latched type from T1 through the final state; in TI they hold their last value.
REQ-024 rd_=0 in T2/TW/T3 for OF, MR, DR; wr_=0 in T2/TW/T3 for MW, DW; inta_=0 in T2/TW/T3 for INTA; otherwise 1.
REQ-025 TH: hlda=1, bus_en=0; leaves when hold=0, going to TT if entered from TT, else to TI.
REQ-026 TT: halted=1, bus_en=0, s1=s0=0; hold -> TH; intr -> TI; stays in TT otherwise.
REQ-027 bus_en=1 in T1..T6 and TW, 0 elsewhere.
REQ-028 nwait=0 with ready=1 gives 4 T-states (OF), 6 (OF+six) or 3 (other types).

Reset
REQ-029 rst=1 at a clock edge: next state TR; regardless of state or mid-cycle, all strobes are high, ale=0, hlda=0, bus_en=0, done=0, halted=0, s1s0iom_=011, wait count=0.
REQ-030 rst has priority over every other input.

Structure
REQ-031 Shared package cycle_pkg holds the state encodings (TSTSIZE bits) and the cyc_type/status constants.
REQ-032 One sub-module, wait_count: a WAITBITS loadable down-counter with a zero flag.

Verification
REQ-033 MR with nwait=0, ready=1 -> T1,T2,T3; rd_ low 2 clocks; done in T3; return to TI.
REQ-034 OF with six=1, nwait=2, ready=1 -> T1,T2,TW,TW,T3,T4,T5,T6; rd_ low 4 clocks.
REQ-035 MW, nwait=0, ready low 3 clocks after T1 -> 3 TW; wr_ low 5 clocks.
REQ-036 hold raised in T2 of DR -> cycle completes; TH on the next edge; hlda=1, bus_en=0 until hold drops; then TI.
REQ-037 halt_req with req at end of MR -> TT, s1s0=00; hold -> TH -> back to TT; intr -> TI.
REQ-038 rst in TW of INTA -> inta_=1 and bus_en=0 after one edge; TR then TI.
